// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory handshake, IR hand-off to control, and redirect inputs.
interface pc_fetch_unit_if #(
   parameter int XLEN  = 64,
   parameter int ILEN  = 32,
   parameter int CNT_W = 32
);
   logic             imem_req;
   logic [XLEN-1:0]  imem_addr;
   logic [ILEN-1:0]  imem_rdata;
   logic             imem_ready;
   logic [ILEN-1:0]  ir;
   logic             ir_valid;
   logic             instr_ack;
   logic             branch_req;
   logic             jump_req;
   logic [2:0]       branch_funct3;
   logic [XLEN-1:0]  rs1;
   logic [XLEN-1:0]  rs2;
   logic [XLEN-1:0]  target;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  pc_plus4;
   logic             branch_taken;
   logic             fault;
   logic [CNT_W-1:0] retired;

   modport master (
      output imem_req, imem_addr, ir, ir_valid, pc, pc_plus4, branch_taken, fault, retired,
      input  imem_rdata, imem_ready, instr_ack, branch_req, jump_req, branch_funct3,
             rs1, rs2, target
   );

   modport slave (
      input  imem_req, imem_addr, ir, ir_valid, pc, pc_plus4, branch_taken, fault, retired,
      output imem_rdata, imem_ready, instr_ack, branch_req, jump_req, branch_funct3,
             rs1, rs2, target
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the multicycle RISC-V core.
// state | meaning
// START | one idle cycle after reset, memory ignored
// FETCH | imem_req high at pc, waiting for imem_ready
// HOLD  | ir valid, waiting for instr_ack from control
// HALT  | misaligned redirect seen, frozen until reset
module pc_fetch_unit #(
   parameter int              XLEN     = 64,
   parameter int              ILEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic          Clk,
   input  logic          Reset,
   pc_fetch_unit_if.master bus
);
   typedef enum logic [1:0] {START, FETCH, HOLD, HALT} stateT;

   stateT            state;
   logic [XLEN-1:0]  pcReg;
   logic [XLEN-1:0]  pcPlus4;
   logic [ILEN-1:0]  irReg;
   logic             irValid;
   logic             imemReq;
   logic             branchTaken;
   logic             faultReg;
   logic [CNT_W-1:0] retiredCnt;
   logic             condTrue;
   logic             redirect;
   logic             misaligned;

   assign pcPlus4 = pcReg + XLEN'(4);

   always_comb begin
      condTrue = 1'b0;
      case (bus.branch_funct3)
         3'b000:  condTrue = (bus.rs1 == bus.rs2);
         3'b001:  condTrue = (bus.rs1 != bus.rs2);
         3'b100:  condTrue = ($signed(bus.rs1) <  $signed(bus.rs2));
         3'b101:  condTrue = ($signed(bus.rs1) >= $signed(bus.rs2));
         3'b110:  condTrue = (bus.rs1 <  bus.rs2);
         3'b111:  condTrue = (bus.rs1 >= bus.rs2);
         default: condTrue = 1'b0;
      endcase
   end

   // jump_req wins over branch_req, so a jump never depends on funct3.
   assign redirect   = bus.jump_req | (bus.branch_req & condTrue);
   assign misaligned = (bus.target[1:0] != 2'b00);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state       <= START;
         pcReg       <= RESET_PC;
         irReg       <= '0;
         irValid     <= 1'b0;
         imemReq     <= 1'b0;
         branchTaken <= 1'b0;
         faultReg    <= 1'b0;
         retiredCnt  <= '0;
      end else begin
         branchTaken <= 1'b0;
         case (state)
            START: begin
               imemReq <= 1'b1;
               state   <= FETCH;
            end
            FETCH: begin
               if (bus.imem_ready) begin
                  irReg   <= bus.imem_rdata;
                  irValid <= 1'b1;
                  imemReq <= 1'b0;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (bus.instr_ack) begin
                  irValid <= 1'b0;
                  if (redirect && misaligned) begin
                     faultReg <= 1'b1;
                     state    <= HALT;
                  end else begin
                     pcReg       <= redirect ? bus.target : pcPlus4;
                     branchTaken <= redirect;
                     retiredCnt  <= retiredCnt + CNT_W'(1);
                     imemReq     <= 1'b1;
                     state       <= FETCH;
                  end
               end
            end
            HALT: begin
               imemReq <= 1'b0;
               irValid <= 1'b0;
            end
            default: state <= START;
         endcase
      end
   end

   assign bus.imem_req     = imemReq;
   assign bus.imem_addr    = pcReg;
   assign bus.ir           = irReg;
   assign bus.ir_valid     = irValid;
   assign bus.pc           = pcReg;
   assign bus.pc_plus4     = pcPlus4;
   assign bus.branch_taken = branchTaken;
   assign bus.fault        = faultReg;
   assign bus.retired      = retiredCnt;
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised program-counter and instruction-fetch sequencer for the multicycle RISC-V core. It replaces the fixed 64-bit PC register, the PCWrite/PCWriteCond gating and the single zero/not-zero branch mux. It adds:
- a variable-latency instruction-memory handshake
- full RV branch-condition evaluation
- misaligned-target fault detection
- a retired-instruction counter

The control FSM consumes the IR through a valid/ack pair.

Parameters:
XLEN, 64, datapath/PC width in bits (32 or 64)
ILEN, 32, instruction width in bits
RESET_PC, 0, PC value loaded on reset (XLEN bits, must be 4-byte aligned)
CNT_W, 32, width of retired-instruction counter

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  asynchronous active-low reset (0 = reset)
imem_req  output  1  fetch request, held high until imem_ready
imem_addr  output  XLEN  fetch address, equals pc while imem_req=1
imem_rdata  input  ILEN  fetched instruction, sampled when imem_req & imem_ready
imem_ready  input  1  memory completes fetch this cycle
ir  output  ILEN  instruction register
ir_valid  output  1  ir holds an unconsumed instruction
instr_ack  input  1  control unit finished current instruction
branch_req  input  1  with ack: instruction is a conditional branch
jump_req  input  1  with ack: unconditional redirect (jal/jalr)
branch_funct3  input  3  branch condition code
rs1  input  XLEN  branch compare operand A
rs2  input  XLEN  branch compare operand B
target  input  XLEN  redirect address (precomputed by ALU)
pc  output  XLEN  current PC
pc_plus4  output  XLEN  pc+4, combinational, wraps modulo 2^XLEN
branch_taken  output  1  one-cycle pulse on redirect
fault  output  1  sticky misaligned-target fault
retired  output  CNT_W  count of acknowledged instructions

Behaviour:
- Reset (async, Reset=0) forces:
  - state=START, pc=RESET_PC, ir=0, retired=0
  - ir_valid=0, imem_req=0, branch_taken=0, fault=0
- START: one cycle with imem_req=0, then FETCH. Any imem_ready seen in START is ignored.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ready=1: ir<=imem_rdata, ir_valid<=1, go to HOLD.
  - Minimum latency is 1 cycle (ready in the first FETCH cycle). Wait states are unbounded.
- HOLD: imem_req=0, ir stable, waiting for instr_ack.
  - Ack with branch_req=0 and jump_req=0: pc<=pc+4, ir_valid<=0, retired+1, go to FETCH.
  - Ack with jump_req=1, or branch_req=1 with condition true: redirect.
    - If target[1:0]==0: pc<=target, branch_taken=1 for one cycle, retired+1, ir_valid<=0, go to FETCH.
    - If target[1:0]!=0: pc unchanged, fault<=1, ir_valid<=0, retired unchanged, go to HALT.
  - Ack with branch_req=1 and condition false: same as the sequential case (pc+4).
  - jump_req takes priority over branch_req when both are set.
- Branch conditions (branch_funct3):
  - 000 eq, 001 ne
  - 100 signed lt, 101 signed ge
  - 110 unsigned lt, 111 unsigned ge
  - 010 and 011 never taken
- HALT: imem_req=0, ir_valid=0, pc and ir frozen, fault=1. Only reset exits HALT.
- instr_ack outside HOLD is ignored.
- pc arithmetic wraps modulo 2^XLEN. retired wraps modulo 2^CNT_W.
- Reset asserted mid-fetch abandons the request immediately. A late imem_ready after reset release is ignored (START state).

Test Plan:
1. Reset with RESET_PC=0x100, ready on the first FETCH cycle -> imem_addr=0x100; ir=0x00000013, ir_valid=1; ack -> pc=0x104, retired=1.
2. imem_ready delayed 3 cycles -> imem_req and imem_addr=0x104 held for 3 cycles; ir loads only on the ready cycle; ir_valid stays 0 until then.
3. branch_req=1, funct3=100, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1, target=0x200 -> taken (-1<1 signed), pc=0x200, branch_taken pulse; the same operands with funct3=110 -> not taken, pc=pc+4.
4. jump_req=1, target=0x202 -> fault=1, pc unchanged, state HALT; later imem_ready and instr_ack have no effect until Reset=0.
5. XLEN=32, pc=0xFFFF_FFFC, sequential ack -> pc=0x0000_0000. CNT_W=4 with 16 acks -> retired=0.
6. Reset pulled low during a FETCH wait state, then released while imem_ready=1 -> ready ignored in START; the next FETCH is at RESET_PC, and retired=0.
